// File: rtl/priority_encoder_pkg.sv
// Shared definitions for the MSB-first priority encoder.
//   pe_width(n) : width of the index output for an n-bit request vector.
//                 Instantiating modules use it to size their Y nets.
package priority_encoder_pkg;

  localparam int PE_DEFAULT_N = 16;

  // A 1-bit vector still needs a 1-bit index port, so the width never drops
  // below 1.
  function automatic int pe_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_encoder_node.sv
// One merge node of the priority-encoder tree.
//   Combines a low child and a high child, each a (valid, index) pair.
//   The high child wins whenever it is valid; otherwise the low child's
//   result passes through. The winning side is recorded in bit SB of the
//   index.
// Parameters:
//   W   index width (full output width; unused upper bits stay zero)
//   SB  bit position that encodes the child select at this tree level
// Ports:
//   lo_v_i, lo_idx_i   low child valid / index
//   hi_v_i, hi_idx_i   high child valid / index
//   v_o, idx_o         merged valid / index
module priority_encoder_node #(
  parameter int W  = 4,
  parameter int SB = 0
) (
  input  logic         lo_v_i,
  input  logic [W-1:0] lo_idx_i,
  input  logic         hi_v_i,
  input  logic [W-1:0] hi_idx_i,
  output logic         v_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] sel;

  always_comb begin
    sel     = '0;
    sel[SB] = 1'b1;
  end

  assign v_o   = hi_v_i | lo_v_i;
  // Children carry zeros at SB and above, so OR-ing sets just the select bit.
  // An empty subtree yields index 0 through the low path.
  assign idx_o = hi_v_i ? (hi_idx_i | sel) : lo_idx_i;

endmodule

// File: rtl/priority_encoder.sv
// MSB-first priority encoder: Y is the index of the highest set bit of A,
// empty flags A == 0 (Y is then 0, same as A == 1).
// Build option: PRIORITY_ENCODER_REG_OUT_EN
//   undefined : Y/empty are combinational from A; clock and reset unused.
//   defined   : Y/empty registered on posedge clock (1-cycle latency);
//               synchronous active-high reset forces Y=0, empty=1.
// Parameters:
//   N  request vector width (N >= 1); Y width is derived via pe_width(N).
// Ports:
//   clock  in  1   clock (registered build only)
//   reset  in  1   synchronous active-high reset (registered build only)
//   A      in  N   request vector, bit N-1 highest priority
//   Y      out W   index of highest set bit, 0 when A == 0
//   empty  out 1   1 iff A == 0
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int N = PE_DEFAULT_N
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           A,
  output logic [pe_width(N)-1:0] Y,
  output logic                   empty
);

  localparam int W = pe_width(N);
  // The tree works on a power-of-two width; the padding bits are zero, so
  // indices >= N are never produced.
  localparam int P = 1 << W;

  logic [P-1:0] a_pad;
  assign a_pad = P'(A);

  // Heap-ordered tree: node k has children 2k (low) and 2k+1 (high); leaves
  // sit at P..2P-1 and the root is node 1.
  logic [2*P-1:1]        nv;
  logic [2*P-1:1][W-1:0] nidx;

  for (genvar i = 0; i < P; i++) begin : g_leaf
    assign nv[P+i]   = a_pad[i];
    assign nidx[P+i] = '0;
  end

  // Node k sits at depth floor(log2 k); its select bit is W-1 minus that.
  for (genvar k = 1; k < P; k++) begin : g_node
    priority_encoder_node #(
      .W  (W),
      .SB (W - $clog2(k + 1))
    ) u_node (
      .lo_v_i   (nv[2*k]),
      .lo_idx_i (nidx[2*k]),
      .hi_v_i   (nv[2*k+1]),
      .hi_idx_i (nidx[2*k+1]),
      .v_o      (nv[k]),
      .idx_o    (nidx[k])
    );
  end

  logic [W-1:0] y_d;
  logic         empty_d;

  assign y_d     = nidx[1];
  assign empty_d = ~nv[1];

`ifdef PRIORITY_ENCODER_REG_OUT_EN
  logic [W-1:0] y_q;
  logic         empty_q;

  // Reset values match the A == 0 encoding.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_q     <= '0;
      empty_q <= 1'b1;
    end else begin
      y_q     <= y_d;
      empty_q <= empty_d;
    end
  end

  assign Y     = y_q;
  assign empty = empty_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;

  assign Y     = y_d;
  assign empty = empty_d;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0] a16 = '0;
  logic [3:0]  y16;
  logic        e16;
  logic [4:0]  a5  = '0;
  logic [2:0]  y5;
  logic        e5;
  logic        a1  = 1'b0;
  logic        y1;
  logic        e1;

  priority_encoder #(.N(16)) u_dut16 (.clock(clock), .reset(reset), .A(a16), .Y(y16), .empty(e16));
  priority_encoder #(.N(5))  u_dut5  (.clock(clock), .reset(reset), .A(a5),  .Y(y5),  .empty(e5));
  priority_encoder #(.N(1))  u_dut1  (.clock(clock), .reset(reset), .A(a1),  .Y(y1),  .empty(e1));

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] y;
    logic       e;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: highest set bit by linear scan.
  function automatic logic [3:0] ref_y(input logic [15:0] a);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (a[i]) r = 4'(i);
    return r;
  endfunction

  // Wait until outputs reflect the inputs just driven.
  task automatic settle();
`ifdef PRIORITY_ENCODER_REG_OUT_EN
    @(posedge clock);
    #1;
`else
    #2;
`endif
  endtask

  task automatic apply16(input logic [15:0] a, input logic rst, input string tag);
    exp_t e;
    logic rst_eff;
`ifdef PRIORITY_ENCODER_REG_OUT_EN
    rst_eff = rst;
`else
    rst_eff = 1'b0;
`endif
    @(negedge clock);
    reset = rst;
    a16   = a;
    if (rst_eff) sb.push_back('{y: 4'd0, e: 1'b1});
    else         sb.push_back('{y: ref_y(a), e: (a == 16'h0)});
    settle();
    if (sb.size() == 0) begin
      chk({tag, " sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " Y"}, 32'(y16), 32'(e.y));
      chk({tag, " empty"}, 32'(e16), 32'(e.e));
    end
  endtask

  initial begin
    // Reset held for two cycles with A = 0.
    repeat (2) @(posedge clock);
    #1;
    chk("reset Y", 32'(y16), 32'd0);
    chk("reset empty", 32'(e16), 32'd1);

    // Boundaries and priority.
    apply16(16'h0000, 1'b0, "a0000");
    apply16(16'h0001, 1'b0, "a0001");
    apply16(16'h8000, 1'b0, "a8000");
    apply16(16'hFFFF, 1'b0, "aFFFF");
    apply16(16'h0101, 1'b0, "a0101");
    apply16(16'h00F0, 1'b0, "a00F0");
    apply16(16'h0003, 1'b0, "a0003");
    apply16(16'h0400, 1'b0, "a0400");

    // Reset mid-stream (overrides A only in the registered build).
    apply16(16'h8000, 1'b1, "rst_mid");
    apply16(16'h8000, 1'b0, "post_rst");

    // Non-power-of-two and single-bit widths.
    @(negedge clock);
    a5 = 5'b10000;
    a1 = 1'b0;
    settle();
    chk("n5 10000 Y", 32'(y5), 32'd4);
    chk("n5 10000 empty", 32'(e5), 32'd0);
    chk("n1 a0 Y", 32'(y1), 32'd0);
    chk("n1 a0 empty", 32'(e1), 32'd1);

    @(negedge clock);
    a5 = 5'b11111;
    a1 = 1'b1;
    settle();
    chk("n5 11111 Y", 32'(y5), 32'd4);
    chk("n1 a1 Y", 32'(y1), 32'd0);
    chk("n1 a1 empty", 32'(e1), 32'd0);

    @(negedge clock);
    a5 = 5'b00000;
    settle();
    chk("n5 0 Y", 32'(y5), 32'd0);
    chk("n5 0 empty", 32'(e5), 32'd1);

    @(negedge clock);
    a5 = 5'b00110;
    settle();
    chk("n5 00110 Y", 32'(y5), 32'd2);

    // Exhaustive sweep of the 16-bit encoder.
    for (int i = 0; i < 65536; i++)
      apply16(16'(i), 1'b0, "exh");

    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
